// File: rtl/kmap_pkg.sv
// Shared sizes, state encoding and width helper for the K-map sweep controller.
package kmap_pkg;

  localparam int N_VARS = 4;
  localparam int ROWS   = 1 << N_VARS;

  function automatic int popcnt_width(input int rows);
    return $clog2(rows + 1);
  endfunction

  // ones_cnt must hold the value ROWS itself (constant-1 function).
  localparam int CNT_W = popcnt_width(ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } kmap_state_t;

endpackage

// File: rtl/kmap_sweep_ctrl_if.sv
// Bundle between a sweep driver (master) and the sweep controller (slave).
interface kmap_sweep_ctrl_if;

  logic                             start;
  logic [kmap_pkg::ROWS-1:0]        expected;
  logic [kmap_pkg::N_VARS-1:0]      abcd;
  logic                             dut_out;
  logic                             busy;
  logic                             done;
  logic [kmap_pkg::ROWS-1:0]        result;
  logic [kmap_pkg::CNT_W-1:0]       ones_cnt;
  logic                             mismatch;
  logic [kmap_pkg::N_VARS-1:0]      first_err;

  modport master (
    output start, expected, dut_out,
    input  abcd, busy, done, result, ones_cnt, mismatch, first_err
  );

  modport slave (
    input  start, expected, dut_out,
    output abcd, busy, done, result, ones_cnt, mismatch, first_err
  );

endinterface

// File: rtl/kmap_settle_cnt.sv
// Loadable down-counter: expire is high once SETTLE_CYC cycles of enable have elapsed.
module kmap_settle_cnt #(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYC - 1);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (en && cnt_reg != 4'd0) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Expire is combinational on the count so SETTLE lasts exactly SETTLE_CYC cycles.
  assign expire = (cnt_reg == 4'd0);

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Steps a 4-input function block through all vectors, captures its truth table and scores it.
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  kmap_sweep_ctrl_if.slave   bus
);

  kmap_state_t         state_reg;
  logic [N_VARS-1:0]   idx_reg;
  logic [N_VARS-1:0]   abcd_reg;
  logic [ROWS-1:0]     exp_reg;
  logic [ROWS-1:0]     result_reg;
  logic [CNT_W-1:0]    ones_reg;
  logic                mismatch_reg;
  logic [N_VARS-1:0]   first_err_reg;
  logic                busy_reg;
  logic                done_reg;

  logic                accept;
  logic                last_row;
  logic                cnt_load;
  logic                cnt_expire;

  assign accept   = (state_reg == IDLE) && bus.start;
  assign last_row = (idx_reg == N_VARS'(ROWS - 1));
  assign cnt_load = accept || ((state_reg == SAMPLE) && !last_row);

  kmap_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .en     (state_reg == SETTLE),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      abcd_reg      <= '0;
      exp_reg       <= '0;
      result_reg    <= '0;
      ones_reg      <= '0;
      mismatch_reg  <= 1'b0;
      first_err_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            exp_reg       <= bus.expected;
            idx_reg       <= '0;
            abcd_reg      <= '0;
            result_reg    <= '0;
            ones_reg      <= '0;
            mismatch_reg  <= 1'b0;
            first_err_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_expire) begin
            state_reg <= SAMPLE;
          end
        end
        SAMPLE: begin
          result_reg[idx_reg] <= bus.dut_out;
          ones_reg            <= ones_reg + {{(CNT_W-1){1'b0}}, bus.dut_out};
          // Only the lowest failing row is kept; later ones leave first_err alone.
          if ((bus.dut_out != exp_reg[idx_reg]) && !mismatch_reg) begin
            mismatch_reg  <= 1'b1;
            first_err_reg <= idx_reg;
          end
          if (last_row) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            abcd_reg  <= idx_reg + 1'b1;
            state_reg <= SETTLE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.abcd      = abcd_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.result    = result_reg;
  assign bus.ones_cnt  = ones_reg;
  assign bus.mismatch  = mismatch_reg;
  assign bus.first_err = first_err_reg;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: ideal/constant/faulty function models, two settle lengths.
module tb_kmap_sweep_ctrl;
  import kmap_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kmap_sweep_ctrl_if bus1 ();
  kmap_sweep_ctrl_if bus3 ();

  kmap_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  kmap_sweep_ctrl #(.SETTLE_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [15:0] exp1   = '0;
  logic [15:0] exp3   = '0;
  int          mode      = 0;   // 0: a^b^c^d, 1: constant 1, 2: constant 0
  int          fault_row = -1;  // row whose output is inverted, -1 for none

  int checks = 0;
  int errors = 0;

  function automatic logic model(input logic [3:0] v, input int m, input int fr);
    logic r;
    case (m)
      0:       r = ^v;
      1:       r = 1'b1;
      default: r = 1'b0;
    endcase
    if (fr >= 0 && int'(v) == fr) r = ~r;
    return r;
  endfunction

  assign bus1.start    = start1;
  assign bus3.start    = start3;
  assign bus1.expected = exp1;
  assign bus3.expected = exp3;
  assign bus1.dut_out  = model(bus1.abcd, mode, fault_row);
  assign bus3.dut_out  = model(bus3.abcd, mode, fault_row);

  // Runs one sweep on instance sel (0: settle 1, 1: settle 3) and measures timing.
  task automatic do_sweep(input bit sel, input logic [15:0] exp_val, input bit chg_exp,
                          input bit pulse_busy, output int done_cyc, output int done_cnt,
                          output int abcd_bad, output int busy_bad);
    int spc;
    logic d, b;
    logic [3:0] a;
    spc = sel ? 4 : 2;
    @(negedge clk);
    if (sel) begin start3 = 1'b1; exp3 = exp_val; end
    else     begin start1 = 1'b1; exp1 = exp_val; end
    @(posedge clk);
    done_cyc = -1; done_cnt = 0; abcd_bad = 0; busy_bad = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (sel) start3 = 1'b0;
      else     start1 = pulse_busy && (k == 5 || k == 20);
      if (chg_exp) begin
        if (sel) exp3 = ~exp_val; else exp1 = ~exp_val;
      end
      d = sel ? bus3.done : bus1.done;
      b = sel ? bus3.busy : bus1.busy;
      a = sel ? bus3.abcd : bus1.abcd;
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc < 0 || k == done_cyc) begin
        if (b !== 1'b1) busy_bad++;
        if (k <= ROWS * spc && int'(a) != (k - 1) / spc) abcd_bad++;
      end else if (b !== 1'b0) begin
        busy_bad++;
      end
      if (done_cyc > 0 && k >= done_cyc + 3) break;
    end
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus1.abcd !== 4'd0) begin errors++; $display("FAIL reset_abcd got %0h want 0", bus1.abcd); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus1.done); end
    checks++; if (bus1.result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", bus1.result); end
    checks++; if (bus1.ones_cnt !== 5'd0) begin errors++; $display("FAIL reset_ones got %0d want 0", bus1.ones_cnt); end
    checks++; if (bus1.mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", bus1.mismatch); end
    checks++; if (bus1.first_err !== 4'd0) begin errors++; $display("FAIL reset_first_err got %0d want 0", bus1.first_err); end
    checks++; if (bus3.busy !== 1'b0 || bus3.result !== 16'h0) begin errors++; $display("FAIL reset_inst3 got busy=%b result=%h want 0/0000", bus3.busy, bus3.result); end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_pass_sweep();
    int dc, dn, ab, bb;
    mode = 0; fault_row = -1;
    do_sweep(1'b0, 16'h6996, 1'b0, 1'b0, dc, dn, ab, bb);
    checks++; if (dc !== 33) begin errors++; $display("FAIL pass_done_cycle got %0d want 33", dc); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL pass_done_count got %0d want 1", dn); end
    checks++; if (ab !== 0) begin errors++; $display("FAIL pass_abcd_seq got %0d bad cycles want 0", ab); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL pass_busy got %0d bad cycles want 0", bb); end
    checks++; if (bus1.result !== 16'h6996) begin errors++; $display("FAIL pass_result got %h want 6996", bus1.result); end
    checks++; if (bus1.ones_cnt !== 5'd8) begin errors++; $display("FAIL pass_ones got %0d want 8", bus1.ones_cnt); end
    checks++; if (bus1.mismatch !== 1'b0) begin errors++; $display("FAIL pass_mismatch got %b want 0", bus1.mismatch); end
    repeat (5) @(negedge clk);
    checks++; if (bus1.result !== 16'h6996) begin errors++; $display("FAIL pass_result_held got %h want 6996", bus1.result); end
    $display("pass_sweep: done at %0d result %h ones %0d", dc, bus1.result, bus1.ones_cnt);
  endtask

  task automatic test_single_mismatch();
    int dc, dn, ab, bb;
    mode = 0; fault_row = -1;
    do_sweep(1'b0, 16'h6997, 1'b0, 1'b0, dc, dn, ab, bb);
    checks++; if (bus1.mismatch !== 1'b1) begin errors++; $display("FAIL single_mismatch got %b want 1", bus1.mismatch); end
    checks++; if (bus1.first_err !== 4'd0) begin errors++; $display("FAIL single_first_err got %0d want 0", bus1.first_err); end
    checks++; if (bus1.result !== 16'h6996) begin errors++; $display("FAIL single_result got %h want 6996", bus1.result); end
    $display("single_mismatch: first_err %0d", bus1.first_err);
  endtask

  task automatic test_two_mismatch();
    int dc, dn, ab, bb;
    mode = 0; fault_row = 11;
    // expected is also inverted mid-sweep; the latched copy must be used.
    do_sweep(1'b0, 16'h6986, 1'b1, 1'b0, dc, dn, ab, bb);
    fault_row = -1;
    checks++; if (bus1.mismatch !== 1'b1) begin errors++; $display("FAIL two_mismatch got %b want 1", bus1.mismatch); end
    checks++; if (bus1.first_err !== 4'd4) begin errors++; $display("FAIL two_first_err got %0d want 4", bus1.first_err); end
    checks++; if (bus1.result !== 16'h6196) begin errors++; $display("FAIL two_result got %h want 6196", bus1.result); end
    checks++; if (bus1.ones_cnt !== 5'd7) begin errors++; $display("FAIL two_ones got %0d want 7", bus1.ones_cnt); end
    $display("two_mismatch: first_err %0d result %h", bus1.first_err, bus1.result);
  endtask

  task automatic test_constants();
    int dc, dn, ab, bb;
    mode = 1; fault_row = -1;
    do_sweep(1'b0, 16'hFFFF, 1'b0, 1'b0, dc, dn, ab, bb);
    checks++; if (bus1.ones_cnt !== 5'd16) begin errors++; $display("FAIL const1_ones got %0d want 16", bus1.ones_cnt); end
    checks++; if (bus1.result !== 16'hFFFF || bus1.mismatch !== 1'b0) begin errors++; $display("FAIL const1_result got %h/%b want FFFF/0", bus1.result, bus1.mismatch); end
    $display("const_one: ones %0d", bus1.ones_cnt);
    mode = 2;
    do_sweep(1'b1, 16'h0000, 1'b0, 1'b0, dc, dn, ab, bb);
    checks++; if (dc !== 65) begin errors++; $display("FAIL settle3_done_cycle got %0d want 65", dc); end
    checks++; if (ab !== 0) begin errors++; $display("FAIL settle3_abcd_seq got %0d bad cycles want 0", ab); end
    checks++; if (bus3.ones_cnt !== 5'd0 || bus3.mismatch !== 1'b0) begin errors++; $display("FAIL settle3_result got ones=%0d mm=%b want 0/0", bus3.ones_cnt, bus3.mismatch); end
    $display("const_zero_settle3: done at %0d ones %0d", dc, bus3.ones_cnt);
  endtask

  task automatic test_start_while_busy();
    int dc, dn, ab, bb;
    mode = 0; fault_row = -1;
    do_sweep(1'b0, 16'h6996, 1'b0, 1'b1, dc, dn, ab, bb);
    checks++; if (dc !== 33) begin errors++; $display("FAIL busy_start_done_cycle got %0d want 33", dc); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", dn); end
    checks++; if (ab !== 0 || bb !== 0) begin errors++; $display("FAIL busy_start_seq got abcd_bad=%0d busy_bad=%0d want 0/0", ab, bb); end
    $display("start_while_busy: done at %0d pulses %0d", dc, dn);
  endtask

  task automatic test_back_to_back();
    int dc;
    mode = 0; fault_row = -1;
    @(negedge clk); start1 = 1'b1; exp1 = 16'h6996;
    @(posedge clk);
    dc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin dc = k; break; end
    end
    checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_first_done got %0d want 33", dc); end
    @(negedge clk);
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%b want 0", bus1.busy); end
    @(negedge clk);
    start1 = 1'b0;
    checks++; if (bus1.busy !== 1'b1 || bus1.abcd !== 4'd0) begin errors++; $display("FAIL b2b_restart got busy=%b abcd=%0d want 1/0", bus1.busy, bus1.abcd); end
    dc = -1;
    for (int k = 1; k <= 60; k++) begin
      if (bus1.done === 1'b1) begin dc = k; break; end
      @(negedge clk);
    end
    checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_second_done got %0d want 33", dc); end
    checks++; if (bus1.result !== 16'h6996) begin errors++; $display("FAIL b2b_result got %h want 6996", bus1.result); end
    $display("back_to_back: second done at %0d", dc);
  endtask

  task automatic test_reset_mid();
    int dc, dn, ab, bb, stray;
    mode = 0; fault_row = -1;
    @(negedge clk); start1 = 1'b1; exp1 = 16'h6996;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus1.busy !== 1'b0 || bus1.abcd !== 4'd0) begin errors++; $display("FAIL rstmid_state got busy=%b abcd=%0d want 0/0", bus1.busy, bus1.abcd); end
    checks++; if (bus1.result !== 16'h0 || bus1.done !== 1'b0) begin errors++; $display("FAIL rstmid_result got result=%h done=%b want 0000/0", bus1.result, bus1.done); end
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus1.done === 1'b1) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", stray); end
    do_sweep(1'b0, 16'h6996, 1'b0, 1'b0, dc, dn, ab, bb);
    checks++; if (dc !== 33 || bus1.result !== 16'h6996 || bus1.ones_cnt !== 5'd8) begin errors++; $display("FAIL rstmid_rerun got done=%0d result=%h ones=%0d want 33/6996/8", dc, bus1.result, bus1.ones_cnt); end
    $display("reset_mid: rerun done at %0d result %h", dc, bus1.result);
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_single_mismatch();
    test_two_mismatch();
    test_constants();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmap_sweep_ctrl.md
Name: kmap_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 4-input K-map evaluation datapath (mux-based function block with inputs a, b, c, d and output out).
- Drives every input combination in ascending order and waits a programmable settle time before sampling out.
- Assembles the measured truth table, compares it against an expected truth table, and reports the minterm count and the first mismatch.
- Sits between a lab top level or bench driver and the function block under test.

Parameters:
- N_VARS, 4, number of function inputs; ROWS = 2**N_VARS truth-table rows.
- SETTLE_CYC, 1, cycles the vector is held before sampling (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; accepted only in IDLE.
- expected  in  ROWS  expected truth table; bit i is the expected output for input vector i. Latched when start is accepted.
- abcd  out  N_VARS  vector driven to the function block; {a,b,c,d} = abcd[3:0].
- dut_out  in  1  function block output (out).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when the sweep completes.
- result  out  ROWS  measured truth table; bit i = dut_out sampled for vector i.
- ones_cnt  out  N_VARS+1  number of 1 bits in result (minterm count).
- mismatch  out  1  sticky; set if any sampled bit differs from expected.
- first_err  out  N_VARS  index of the first mismatching vector; valid only when mismatch=1.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; abcd=0, busy=0, done=0, result=0, ones_cnt=0, mismatch=0, first_err=0; internal idx=0, wait_cnt=0, exp_q=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1: exp_q<=expected; idx<=0; abcd<=0; wait_cnt<=0; result<=0; ones_cnt<=0; mismatch<=0; first_err<=0; go to SETTLE.
  - Otherwise hold all outputs, so results from the last sweep remain readable.
- SETTLE: if wait_cnt==SETTLE_CYC-1, go to SAMPLE; else wait_cnt<=wait_cnt+1. abcd is held stable.
- SAMPLE:
  - result[idx]<=dut_out.
  - ones_cnt<=ones_cnt+dut_out.
  - If dut_out!=exp_q[idx] and mismatch==0: mismatch<=1, first_err<=idx.
  - If idx==ROWS-1, go to DONE. Else idx<=idx+1, abcd<=idx+1, wait_cnt<=0, go to SETTLE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in SETTLE, SAMPLE and DONE; 0 in IDLE.
- Latency: done is high in cycle ROWS*(SETTLE_CYC+1)+1 after the start-accept edge. Defaults give 33 cycles.
- start while busy is ignored and never queued.
- start held high continuously: a new sweep begins on the first cycle back in IDLE, i.e. the cycle after done.
- Change of expected during a sweep has no effect because exp_q is latched at start.
- Only the lowest mismatching index is reported; later mismatches leave first_err unchanged.
- idx never wraps: ROWS-1 is terminal.
- ones_cnt reaches ROWS (16) for a constant-1 function, hence width N_VARS+1.
- rst mid-sweep: all state and outputs return to reset values on the next edge, and a partial result is discarded. No done pulse is generated.
- abcd changes only on the SAMPLE->SETTLE transition and on start accept (to 0). It never glitches in other states.

Decomposition:
- Package kmap_pkg:
  - localparams N_VARS=4 and ROWS=16.
  - enum kmap_state_t {IDLE, SETTLE, SAMPLE, DONE}, 2-bit encoding.
  - Helper function for the popcount width.
- Sub-module kmap_settle_cnt, a natural split: a load/enable down-counter that asserts expire after SETTLE_CYC cycles. The FSM, index register and scoreboard logic stay in kmap_sweep_ctrl.

Test Plan:
- Pass sweep, default params: connect an ideal model out=a^b^c^d; expected=16'h6996; pulse start.
  - abcd steps 0..15, each held 2 cycles.
  - done at cycle 33, result=16'h6996, ones_cnt=8, mismatch=0.
- Single mismatch: same model with expected=16'h6997.
  - mismatch=1, first_err=0, result=16'h6996.
- Two mismatches: expected=16'h6986 (row 4 wrong) plus a forced fault at row 11.
  - first_err=4 (lowest index wins), mismatch=1.
- Constant functions and settle length:
  - out=1, expected=16'hFFFF: ones_cnt=16.
  - out=0, SETTLE_CYC=3: done at cycle 65, ones_cnt=0.
- start while busy: pulse start at cycles 5 and 20 of a sweep.
  - Both are ignored, abcd sequence is unaffected, exactly one done pulse at cycle 33.
- Reset mid-sweep: assert rst at cycle 10 for 1 cycle.
  - Next cycle: busy=0, abcd=0, result=0, no done pulse.
  - A subsequent start runs a full 33-cycle sweep with correct results.
